// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and IF/ID register with branch/jump redirect, stall, halt-on-zero FSM
//   clk, rst          : clock, async active-high reset
//   stall             : hold PC and IF/ID
//   branch_taken/offs : relative redirect from decode (instruction-count offset)
//   jump/jump_target  : absolute redirect (bit 0 cleared)
//   pc / instr_in     : instruction memory address / returned word (low half used)
//   if_instr/if_pc/if_valid : IF/ID register
//   halted, fetch_count     : FSM status and saturating count of loaded instructions
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    output logic [15:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, target;
    logic [15:0] if_instr_q, if_instr_d, fetch_count_q, fetch_count_d;
    logic        if_valid_q, if_valid_d, br, redirect;

    // a branch only belongs to a live instruction in IF/ID
    assign br       = branch_taken && if_valid_q;
    assign redirect = jump || br;
    assign target   = jump ? {jump_target[31:1], 1'b0}
                           : if_pc_q + PC_STEP + {{15{branch_offset[15]}}, branch_offset, 1'b0};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        if (state_q == RUN) begin
            if (redirect) begin
                pc_d       = target;
                if_valid_d = 1'b0;
            end else if (!stall) begin
                if (instr_in[15:0] == 16'h0000) begin
                    state_d    = HALT;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d          = pc_q + PC_STEP;
                    if_instr_d    = instr_in[15:0];
                    if_pc_d       = pc_q;
                    if_valid_d    = 1'b1;
                    fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
                end
            end
        end else begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
//   drives stall/branch/jump/rst, models instruction memory combinationally from pc
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [15:0] branch_offset = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc, instr_in, if_pc;
    logic [15:0] if_instr, fetch_count;
    logic        if_valid, halted;
    logic [15:0] mem [0:63];
    int checks = 0, errors = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .pc(pc), .instr_in(instr_in), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    // upper half set to all ones: only bits [15:0] may matter
    assign instr_in = {16'hFFFF, mem[pc[6:1]]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [31:0] e_pc, input logic [15:0] e_ins,
                      input logic [31:0] e_ifpc, input logic e_v, input logic [15:0] e_cnt, input logic e_h);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".if_instr"}, {16'h0, if_instr}, {16'h0, e_ins});
        chk({tag, ".if_pc"}, if_pc, e_ifpc);
        chk({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, e_v});
        chk({tag, ".count"}, {16'h0, fetch_count}, {16'h0, e_cnt});
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, e_h});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h5A5A;
        mem[0] = 16'h8180; mem[1] = 16'h2CB2; mem[2] = 16'hDC67; mem[3] = 16'h1111;
        mem[4] = 16'h2222; mem[5] = 16'h3333; mem[6] = 16'h4444;
        #2;
        st("reset", 32'h0, 16'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        #1 rst = 1'b0;
        tick(); st("seq1", 32'd2, 16'h8180, 32'd0, 1'b1, 16'd1, 1'b0);
        tick(); st("seq2", 32'd4, 16'h2CB2, 32'd2, 1'b1, 16'd2, 1'b0);
        tick(); st("seq3", 32'd6, 16'hDC67, 32'd4, 1'b1, 16'd3, 1'b0);
        // restart to reach pc=4 for the stall case
        #1 rst = 1'b1;
        #1 st("rst2", 32'h0, 16'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        tick(); tick();
        st("pre_stall", 32'd4, 16'h2CB2, 32'd2, 1'b1, 16'd2, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); st("stall", 32'd4, 16'h2CB2, 32'd2, 1'b1, 16'd2, 1'b0);
        end
        stall = 1'b0;
        tick(); st("resume", 32'd6, 16'hDC67, 32'd4, 1'b1, 16'd3, 1'b0);
        // branch forward: 4 + 2 + 3*2 = 12
        branch_taken = 1'b1; branch_offset = 16'h0003;
        tick(); st("br_fwd", 32'd12, 16'hDC67, 32'd4, 1'b0, 16'd3, 1'b0);
        // branch ignored while IF/ID invalid
        branch_offset = 16'hFFFE;
        tick(); st("br_ign", 32'd14, 16'h4444, 32'd12, 1'b1, 16'd4, 1'b0);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'd4;
        tick(); st("jmp4", 32'd4, 16'h4444, 32'd12, 1'b0, 16'd4, 1'b0);
        jump = 1'b0;
        tick(); st("refetch4", 32'd6, 16'hDC67, 32'd4, 1'b1, 16'd5, 1'b0);
        // branch backward: 4 + 2 - 4 = 2
        branch_taken = 1'b1;
        tick(); st("br_back", 32'd2, 16'hDC67, 32'd4, 1'b0, 16'd5, 1'b0);
        branch_taken = 1'b0;
        tick(); st("fetch2", 32'd4, 16'h2CB2, 32'd2, 1'b1, 16'd6, 1'b0);
        // jump beats branch and stall, bit 0 cleared
        jump = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0003; jump_target = 32'h9; stall = 1'b1;
        tick(); st("jmp_pri", 32'd8, 16'h2CB2, 32'd2, 1'b0, 16'd6, 1'b0);
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        mem[6] = 16'h0000;
        tick(); st("f8", 32'd10, 16'h2222, 32'd8, 1'b1, 16'd7, 1'b0);
        tick(); st("f10", 32'd12, 16'h3333, 32'd10, 1'b1, 16'd8, 1'b0);
        // zero word at 12 with branch: 10 + 2 + 2 = 14, no halt
        branch_taken = 1'b1; branch_offset = 16'h0001;
        tick(); st("no_halt", 32'd14, 16'h3333, 32'd10, 1'b0, 16'd8, 1'b0);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'd12;
        tick(); st("jmp12", 32'd12, 16'h3333, 32'd10, 1'b0, 16'd8, 1'b0);
        jump = 1'b0;
        tick(); st("halt", 32'd12, 16'h3333, 32'd10, 1'b0, 16'd8, 1'b1);
        jump = 1'b1; jump_target = 32'd0; branch_taken = 1'b1; stall = 1'b1;
        tick(); st("halt_sticky", 32'd12, 16'h3333, 32'd10, 1'b0, 16'd8, 1'b1);
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        // asynchronous reset between edges while halted
        #1 rst = 1'b1;
        #1 st("async_rst", 32'h0, 16'h0, 32'h0, 1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        tick(); st("post_rst", 32'd2, 16'h8180, 32'd0, 1'b1, 16'd1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
